// File: rtl/universal_reg_bank.sv
`default_nettype none
// ============================================================================
// universal_reg_bank: register bank with CLR/LD/INC/DEC and bit-serial
// shift/rotate commands that take one clock per bit.          Rev 1.0
// ============================================================================
module universal_reg_bank #(
    parameter int  DATA_WIDTH = 16,
    parameter int  NUM_REGS   = 4,
    parameter int  SAT_MODE   = 0,
    localparam int ADDR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int AMT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0]      cmd_amt,
    input  logic                  cmd_fill,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  flag_z,
    output logic                  flag_c
);
    localparam logic [3:0] OP_CLR = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;

    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(DATA_WIDTH);
    localparam logic [AMT_W-1:0] ONE_AMT = AMT_W'(1);
    localparam logic [ADDR_W:0]  REG_CNT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [AMT_W-1:0]      cnt;
    logic [3:0]            sh_op;
    logic [ADDR_W-1:0]     sh_addr;
    logic                  sh_fill;

    logic [DATA_WIDTH-1:0] cmd_cur, sh_cur, wr_val, inc_val, dec_val;
    logic [ADDR_W-1:0]     wr_addr;
    logic [AMT_W-1:0]      amt_c;
    logic                  cmd_ok, sh_ok, inc_c, dec_b;
    logic                  wr_en, fl_en, c_new, z_new, done_set, start_shift;

    function automatic logic [DATA_WIDTH-1:0] step_val(input logic [3:0] op,
                                                       input logic [DATA_WIDTH-1:0] r,
                                                       input logic fill);
        case (op)
            OP_SHR:  return {fill, r[DATA_WIDTH-1:1]};
            OP_SHL:  return {r[DATA_WIDTH-2:0], fill};
            OP_ROR:  return {r[0], r[DATA_WIDTH-1:1]};
            OP_ROL:  return {r[DATA_WIDTH-2:0], r[DATA_WIDTH-1]};
            OP_ASR:  return {r[DATA_WIDTH-1], r[DATA_WIDTH-1:1]};
            default: return r;
        endcase
    endfunction

    // Bit leaving the register on one step: MSB for left moves, LSB otherwise.
    function automatic logic step_out(input logic [3:0] op, input logic [DATA_WIDTH-1:0] r);
        return (op == OP_SHL || op == OP_ROL) ? r[DATA_WIDTH-1] : r[0];
    endfunction

    always_comb begin
        cmd_cur = '0;
        sh_cur  = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == ADDR_W'(i)) cmd_cur = regs[i];
            if (sh_addr  == ADDR_W'(i)) sh_cur  = regs[i];
            if (rd_addr  == ADDR_W'(i)) rd_data = regs[i];
        end
    end

    assign cmd_ok = {1'b0, cmd_addr} < REG_CNT;
    assign sh_ok  = {1'b0, sh_addr} < REG_CNT;
    assign amt_c  = (cmd_amt > MAX_AMT) ? MAX_AMT : cmd_amt;

    assign {inc_c, inc_val} = (SAT_MODE != 0 && cmd_cur == '1) ? {1'b1, cmd_cur}
                                                               : {1'b0, cmd_cur} + (DATA_WIDTH + 1)'(1);
    assign dec_b   = (cmd_cur == '0);
    assign dec_val = (SAT_MODE != 0 && dec_b) ? '0 : cmd_cur - DATA_WIDTH'(1);

    always_comb begin
        state_next  = state;
        wr_en       = 1'b0;
        wr_addr     = cmd_addr;
        wr_val      = cmd_cur;
        fl_en       = 1'b0;
        c_new       = 1'b0;
        done_set    = 1'b0;
        start_shift = 1'b0;
        if (state == SHIFT) begin
            wr_addr = sh_addr;
            wr_en   = sh_ok;
            wr_val  = step_val(sh_op, sh_cur, sh_fill);
            c_new   = step_out(sh_op, sh_cur);
            if (cnt == ONE_AMT) begin
                done_set   = 1'b1;
                fl_en      = sh_ok;
                state_next = IDLE;
            end
        end else if (cmd_valid) begin
            done_set = 1'b1;
            case (cmd_op)
                OP_CLR: begin wr_en = cmd_ok; fl_en = cmd_ok; wr_val = '0;       end
                OP_LD:  begin wr_en = cmd_ok; fl_en = cmd_ok; wr_val = cmd_data; end
                OP_INC: begin wr_en = cmd_ok; fl_en = cmd_ok; wr_val = inc_val; c_new = inc_c; end
                OP_DEC: begin wr_en = cmd_ok; fl_en = cmd_ok; wr_val = dec_val; c_new = dec_b; end
                OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: begin
                    fl_en = cmd_ok;
                    if (amt_c != '0) begin
                        wr_en  = cmd_ok;
                        wr_val = step_val(cmd_op, cmd_cur, cmd_fill);
                        c_new  = step_out(cmd_op, cmd_cur);
                        // The first step happens here; the rest are run from SHIFT.
                        if (amt_c != ONE_AMT) begin
                            start_shift = 1'b1;
                            done_set    = 1'b0;
                            fl_en       = 1'b0;
                            state_next  = SHIFT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign z_new     = (wr_val == '0);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            sh_op   <= '0;
            sh_addr <= '0;
            sh_fill <= 1'b0;
        end else begin
            done <= done_set;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_addr == ADDR_W'(i)) regs[i] <= wr_val;
            end
            if (fl_en) begin
                flag_z <= z_new;
                flag_c <= c_new;
            end
            if (start_shift) begin
                cnt     <= amt_c - ONE_AMT;
                sh_op   <= cmd_op;
                sh_addr <= cmd_addr;
                sh_fill <= cmd_fill;
            end else if (state == SHIFT) begin
                cnt <= cnt - ONE_AMT;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_universal_reg_bank.sv
`default_nettype none
// tb_universal_reg_bank: one command stream drives a 3-register wrapping bank and
// a 4-register saturating bank; both are checked every cycle against a model.
module tb_universal_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_op = '0;
    logic [1:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic [4:0]  cmd_amt = '0;
    logic        cmd_fill = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [1:0]  rdy, bsy, dn, fz, fc;
    logic [15:0] rd0, rd1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    universal_reg_bank #(.DATA_WIDTH(16), .NUM_REGS(3), .SAT_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .cmd_fill(cmd_fill), .rd_addr(rd_addr), .rd_data(rd0), .busy(bsy[0]),
        .done(dn[0]), .flag_z(fz[0]), .flag_c(fc[0]));

    universal_reg_bank #(.DATA_WIDTH(16), .NUM_REGS(4), .SAT_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .cmd_fill(cmd_fill), .rd_addr(rd_addr), .rd_data(rd1), .busy(bsy[1]),
        .done(dn[1]), .flag_z(fz[1]), .flag_c(fc[1]));

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- closed-form reference model ----------------
    function automatic int nr(input int i);  return (i == 0) ? 3 : 4; endfunction
    function automatic int clampn(input logic [4:0] a); return (a > 5'd16) ? 16 : int'(a); endfunction
    function automatic logic is_sh(input logic [3:0] op); return op >= 4'd5 && op <= 4'd9; endfunction

    // Value after n single-bit steps, written as whole-word shifts.
    function automatic logic [15:0] sh_val(input logic [3:0] op, input logic [15:0] r, input int n, input logic f);
        logic [15:0] hi, lo;
        if (n == 0) return r;
        hi = 16'hFFFF << (16 - n);
        lo = 16'hFFFF >> (16 - n);
        case (op)
            4'd5:    return (r >> n) | (f ? hi : 16'h0);
            4'd6:    return (r << n) | (f ? lo : 16'h0);
            4'd7:    return (r >> n) | (r << (16 - n));
            4'd8:    return (r << n) | (r >> (16 - n));
            4'd9:    return 16'($signed(r) >>> n);
            default: return r;
        endcase
    endfunction

    function automatic logic sh_c(input logic [3:0] op, input logic [15:0] r, input int n);
        if (n == 0) return 1'b0;
        return (op == 4'd6 || op == 4'd8) ? r[16 - n] : r[n - 1];
    endfunction

    function automatic logic [15:0] res_val(input logic [3:0] op, input logic [15:0] cur, input logic [15:0] d,
                                            input int n, input logic f, input int sat);
        case (op)
            4'd1: return 16'h0;
            4'd2: return d;
            4'd3: return (cur == 16'hFFFF) ? ((sat != 0) ? 16'hFFFF : 16'h0000) : cur + 16'd1;
            4'd4: return (cur == 16'h0000) ? ((sat != 0) ? 16'h0000 : 16'hFFFF) : cur - 16'd1;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: return sh_val(op, cur, n, f);
            default: return cur;
        endcase
    endfunction

    function automatic logic res_c(input logic [3:0] op, input logic [15:0] cur, input int n);
        case (op)
            4'd3: return cur == 16'hFFFF;
            4'd4: return cur == 16'h0000;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: return sh_c(op, cur, n);
            default: return 1'b0;
        endcase
    endfunction

    logic [15:0] mreg [2][4];
    logic [15:0] morig [2];
    logic        mz [2];
    logic        mc [2];
    logic        mbusy, mdone, mfill;
    logic [3:0]  mop;
    logic [1:0]  maddr;
    int          mk, mn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 4; j++) mreg[i][j] <= 16'h0;
                mz[i] <= 1'b0;
                mc[i] <= 1'b0;
                morig[i] <= 16'h0;
            end
            mbusy <= 1'b0; mdone <= 1'b0; mk <= 0; mn <= 0;
            mop <= '0; maddr <= '0; mfill <= 1'b0;
        end else if (mbusy) begin
            for (int i = 0; i < 2; i++) begin
                if (int'(maddr) < nr(i)) begin
                    mreg[i][maddr] <= sh_val(mop, morig[i], mk + 1, mfill);
                    if (mk + 1 == mn) begin
                        mz[i] <= (sh_val(mop, morig[i], mk + 1, mfill) == 16'h0);
                        mc[i] <= sh_c(mop, morig[i], mk + 1);
                    end
                end
            end
            mk <= mk + 1;
            mdone <= (mk + 1 == mn);
            if (mk + 1 == mn) mbusy <= 1'b0;
        end else if (cmd_valid) begin
            if (is_sh(cmd_op) && clampn(cmd_amt) > 1) begin
                mbusy <= 1'b1; mdone <= 1'b0; mk <= 1; mn <= clampn(cmd_amt);
                mop <= cmd_op; maddr <= cmd_addr; mfill <= cmd_fill;
                for (int i = 0; i < 2; i++) begin
                    morig[i] <= mreg[i][cmd_addr];
                    if (int'(cmd_addr) < nr(i))
                        mreg[i][cmd_addr] <= sh_val(cmd_op, mreg[i][cmd_addr], 1, cmd_fill);
                end
            end else begin
                mdone <= 1'b1;
                for (int i = 0; i < 2; i++) begin
                    if (int'(cmd_addr) < nr(i)) begin
                        mreg[i][cmd_addr] <= res_val(cmd_op, mreg[i][cmd_addr], cmd_data, clampn(cmd_amt), cmd_fill, i);
                        if (cmd_op >= 4'd1 && cmd_op <= 4'd9) begin
                            mz[i] <= (res_val(cmd_op, mreg[i][cmd_addr], cmd_data, clampn(cmd_amt), cmd_fill, i) == 16'h0);
                            mc[i] <= res_c(cmd_op, mreg[i][cmd_addr], clampn(cmd_amt));
                        end
                    end
                end
            end
        end else begin
            mdone <= 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("cmd_ready", i, 32'(rdy[i]), 32'(!mbusy));
            chk("busy",      i, 32'(bsy[i]), 32'(mbusy));
            chk("done",      i, 32'(dn[i]),  32'(mdone));
            chk("flag_z",    i, 32'(fz[i]),  32'(mz[i]));
            chk("flag_c",    i, 32'(fc[i]),  32'(mc[i]));
            chk("rd_data",   i, 32'((i == 0) ? rd0 : rd1),
                32'((int'(rd_addr) < nr(i)) ? mreg[i][rd_addr] : 16'h0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [3:0] op, input logic [1:0] a, input logic [15:0] d,
                        input logic [4:0] amt, input logic f);
        int guard = 0;
        while (!rdy[0] && guard < 60) begin
            // Junk offered while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 4'($urandom); cmd_addr = 2'($urandom); cmd_data = 16'($urandom);
            cmd_amt = 5'($urandom); cmd_fill = 1'($urandom);
            tick();
            guard++;
        end
        if (!rdy[0]) chk("ready_timeout", 0, 32'(rdy[0]), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_amt = amt; cmd_fill = f;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (bsy[0] && guard < 60) begin
            tick();
            guard++;
        end
        if (bsy[0]) chk("idle_timeout", 0, 32'(bsy[0]), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_rd", 0, 32'(rd0), 32'h0);
        chk("reset_ready", 0, 32'(rdy), 32'd3);
        chk("reset_busy", 0, 32'(bsy), 32'd0);
        rst_n = 1'b1;
        tick();

        // LD r1=FFFF, INC wraps on the wrapping bank
        rd_addr = 2'd1;
        send(4'd2, 2'd1, 16'hFFFF, 5'd0, 1'b0);
        chk("ld_done", 0, 32'(dn[0]), 32'd1);
        chk("ld_r1", 0, 32'(rd0), 32'hFFFF);
        send(4'd3, 2'd1, 16'h0, 5'd0, 1'b0);
        chk("inc_wrap_r1", 0, 32'(rd0), 32'h0000);
        chk("inc_wrap_z", 0, 32'(fz[0]), 32'd1);
        chk("inc_wrap_c", 0, 32'(fc[0]), 32'd1);
        chk("inc_done", 0, 32'(dn[0]), 32'd1);
        chk("inc_sat_r1", 1, 32'(rd1), 32'hFFFF);

        // DEC at zero: saturating holds, wrapping rolls over
        rd_addr = 2'd2;
        send(4'd2, 2'd2, 16'h0000, 5'd0, 1'b0);
        send(4'd4, 2'd2, 16'h0, 5'd0, 1'b0);
        chk("dec_sat_r2", 1, 32'(rd1), 32'h0000);
        chk("dec_sat_c", 1, 32'(fc[1]), 32'd1);
        chk("dec_wrap_r2", 0, 32'(rd0), 32'hFFFF);
        send(4'd3, 2'd2, 16'h0, 5'd0, 1'b0);
        chk("inc_r2", 1, 32'(rd1), 32'h0001);
        chk("inc_c", 1, 32'(fc[1]), 32'd0);
        chk("inc_z", 1, 32'(fz[1]), 32'd0);

        // ROR by 4 on 0x8001
        rd_addr = 2'd0;
        send(4'd2, 2'd0, 16'h8001, 5'd0, 1'b0);
        send(4'd7, 2'd0, 16'h0, 5'd4, 1'b0);
        b = 0;
        while (bsy[0] && b < 40) begin
            b++;
            tick();
        end
        chk("ror_busy_cycles", 0, 32'(b), 32'd3);
        chk("ror_done", 0, 32'(dn[0]), 32'd1);
        chk("ror_r0", 0, 32'(rd0), 32'h1800);
        chk("ror_r0", 1, 32'(rd1), 32'h1800);
        chk("ror_c", 0, 32'(fc[0]), 32'd0);

        // ASR by 20 clamps to 16; SHL 3 with fill
        rd_addr = 2'd3;
        send(4'd2, 2'd3, 16'h8000, 5'd0, 1'b0);
        send(4'd9, 2'd3, 16'h0, 5'd20, 1'b0);
        wait_idle();
        chk("asr_r3", 1, 32'(rd1), 32'hFFFF);
        chk("asr_c", 1, 32'(fc[1]), 32'd1);
        send(4'd2, 2'd3, 16'h0000, 5'd0, 1'b0);
        send(4'd6, 2'd3, 16'h0, 5'd3, 1'b1);
        wait_idle();
        chk("shl_fill_r3", 1, 32'(rd1), 32'h0007);

        // Out-of-range address on the 3-register bank
        rd_addr = 2'd1;
        send(4'd2, 2'd1, 16'hFFFF, 5'd0, 1'b0);
        send(4'd3, 2'd1, 16'h0, 5'd0, 1'b0);
        rd_addr = 2'd3;
        send(4'd2, 2'd3, 16'h1234, 5'd0, 1'b0);
        chk("oor_done", 0, 32'(dn[0]), 32'd1);
        chk("oor_rd", 0, 32'(rd0), 32'h0000);
        chk("oor_z_kept", 0, 32'(fz[0]), 32'd1);
        chk("oor_c_kept", 0, 32'(fc[0]), 32'd1);

        // Reset in the middle of SHR by 8
        rd_addr = 2'd0;
        send(4'd2, 2'd0, 16'hFF00, 5'd0, 1'b0);
        send(4'd5, 2'd0, 16'h0, 5'd8, 1'b0);
        tick();
        tick();
        chk("shr_mid_r0", 0, 32'(rd0), 32'h1FE0);
        rst_n = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk("abort_rd", 0, 32'(rd0), 32'h0);
            chk("abort_rd", 1, 32'(rd1), 32'h0);
        end
        chk("abort_flags", 0, 32'({fz, fc}), 32'h0);
        chk("abort_ready", 0, 32'(rdy), 32'd3);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_no_done", 0, 32'(dn), 32'd0);

        // Randomized commands
        for (int n = 0; n < 400; n++) begin
            logic [4:0] amt;
            amt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            rd_addr = 2'($urandom);
            if ($urandom_range(0, 3) == 0) tick();
            send(4'($urandom), 2'($urandom), 16'($urandom), amt, 1'($urandom));
        end
        wait_idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
